// File: rtl/phase_seq_pkg.sv
// ----------------------------------------------------------------------------
// phase_seq_pkg : shared phase encodings and dwell helpers.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
package phase_seq_pkg;

  localparam int NUM_PHASES = 6;

  localparam int IDX_IDLE = 0;
  localparam int IDX_P1   = 1;
  localparam int IDX_P2   = 2;
  localparam int IDX_P3   = 3;
  localparam int IDX_P4   = 4;
  localparam int IDX_P5   = 5;

  typedef enum logic [NUM_PHASES-1:0] {
    PH_IDLE = 6'b000001,
    PH_P1   = 6'b000010,
    PH_P2   = 6'b000100,
    PH_P3   = 6'b001000,
    PH_P4   = 6'b010000,
    PH_P5   = 6'b100000
  } phase_e;

  // A dwell of zero would leave a phase invisible, so it behaves as one cycle.
  function automatic int unsigned clamp_dwell(input int unsigned d);
    return (d == 0) ? 32'd1 : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dwell_timer.sv
// ----------------------------------------------------------------------------
// dwell_timer : loadable down-counter with hold, clear and zero flag.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
module dwell_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             hold_i,
  input  logic             clear_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Clear beats hold beats load; the count rests at zero rather than wrapping.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (hold_i) begin
      count_d = count_q;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/phase_sequencer.sv
// ----------------------------------------------------------------------------
// phase_sequencer : one-hot six-phase controller with programmable dwell.
// Optional sticky ERR output when PHASE_SEQ_ERR_EN is defined.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter int          CNT_W = 8,
  parameter int unsigned D1    = 4,
  parameter int unsigned D2    = 2,
  parameter int unsigned D3    = 3,
  parameter int unsigned D4    = 3,
  parameter int unsigned D5    = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RUN,
  input  logic       SKIP,
  input  logic       HOLD,
  input  logic       ABORT,
  output logic [5:0] PHASE,
  output logic       BUSY,
  output logic       CYC_DONE,
  output logic [7:0] CYCLE_CNT
`ifdef PHASE_SEQ_ERR_EN
  ,
  output logic       ERR
`endif
);

  localparam logic [CNT_W-1:0] c_LD1 = CNT_W'(clamp_dwell(D1) - 1);
  localparam logic [CNT_W-1:0] c_LD2 = CNT_W'(clamp_dwell(D2) - 1);
  localparam logic [CNT_W-1:0] c_LD3 = CNT_W'(clamp_dwell(D3) - 1);
  localparam logic [CNT_W-1:0] c_LD4 = CNT_W'(clamp_dwell(D4) - 1);
  localparam logic [CNT_W-1:0] c_LD5 = CNT_W'(clamp_dwell(D5) - 1);

  logic [NUM_PHASES-1:0] phase_q, phase_d;
  logic                  busy_q;
  logic                  done_q, done_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  tmr_load, tmr_hold, tmr_clear, tmr_zero;
  logic [CNT_W-1:0]      tmr_val;
  logic                  legal;
`ifdef PHASE_SEQ_ERR_EN
  logic                  err_q, err_d;
`endif

  assign legal    = $onehot(phase_q);
  assign tmr_hold = HOLD;

  dwell_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_i      (CLK),
    .rst_ni     (RESET),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .hold_i     (tmr_hold),
    .clear_i    (tmr_clear),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    phase_d   = phase_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    tmr_clear = 1'b0;
`ifdef PHASE_SEQ_ERR_EN
    err_d     = err_q;
`endif
    if (!legal) begin
      phase_d   = PH_IDLE;
      tmr_clear = 1'b1;
`ifdef PHASE_SEQ_ERR_EN
      err_d     = 1'b1;
`endif
    end else if (ABORT) begin
      phase_d   = PH_IDLE;
      tmr_clear = 1'b1;
    end else if (!HOLD) begin
      // A phase advances on the edge where its timer has already reached zero.
      case (phase_q)
        PH_IDLE: if (RUN) begin
          phase_d  = PH_P1;
          tmr_load = 1'b1;
          tmr_val  = c_LD1;
        end
        PH_P1: if (tmr_zero) begin
          phase_d  = PH_P2;
          tmr_load = 1'b1;
          tmr_val  = c_LD2;
        end
        PH_P2: if (tmr_zero) begin
          tmr_load = 1'b1;
          if (SKIP) begin
            phase_d = PH_P5;
            tmr_val = c_LD5;
          end else begin
            phase_d = PH_P3;
            tmr_val = c_LD3;
          end
        end
        PH_P3: if (tmr_zero) begin
          phase_d  = PH_P4;
          tmr_load = 1'b1;
          tmr_val  = c_LD4;
        end
        PH_P4: if (tmr_zero) begin
          phase_d  = PH_P5;
          tmr_load = 1'b1;
          tmr_val  = c_LD5;
        end
        PH_P5: if (tmr_zero) begin
          done_d = 1'b1;
          cnt_d  = cnt_q + 8'd1;
          if (RUN) begin
            phase_d  = PH_P1;
            tmr_load = 1'b1;
            tmr_val  = c_LD1;
          end else begin
            phase_d = PH_IDLE;
          end
        end
        default: phase_d = PH_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      phase_q <= PH_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= 8'd0;
`ifdef PHASE_SEQ_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      phase_q <= phase_d;
      busy_q  <= ~phase_d[IDX_IDLE];
      done_q  <= done_d;
      cnt_q   <= cnt_d;
`ifdef PHASE_SEQ_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  assign PHASE     = phase_q;
  assign BUSY      = busy_q;
  assign CYC_DONE  = done_q;
  assign CYCLE_CNT = cnt_q;
`ifdef PHASE_SEQ_ERR_EN
  assign ERR       = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_phase_sequencer.sv
// ----------------------------------------------------------------------------
// tb_phase_sequencer : scoreboard bench for phase_sequencer.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
module tb_phase_sequencer;

  localparam logic [5:0] S_IDLE = 6'b000001;
  localparam logic [5:0] S_P1   = 6'b000010;
  localparam logic [5:0] S_P2   = 6'b000100;
  localparam logic [5:0] S_P3   = 6'b001000;
  localparam logic [5:0] S_P4   = 6'b010000;
  localparam logic [5:0] S_P5   = 6'b100000;

  logic       CLK   = 1'b0;
  logic       RESET = 1'b0;
  logic       RUN   = 1'b0;
  logic       SKIP  = 1'b0;
  logic       HOLD  = 1'b0;
  logic       ABORT = 1'b0;
  logic [5:0] PHASE;
  logic       BUSY;
  logic       CYC_DONE;
  logic [7:0] CYCLE_CNT;
`ifdef PHASE_SEQ_ERR_EN
  logic       ERR;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    int         at;
    string      tag;
    logic [5:0] ph;
    logic       busy;
    logic       done;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];

  phase_sequencer #(
    .CNT_W (8),
    .D1    (4),
    .D2    (2),
    .D3    (3),
    .D4    (3),
    .D5    (2)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .RUN       (RUN),
    .SKIP      (SKIP),
    .HOLD      (HOLD),
    .ABORT     (ABORT),
    .PHASE     (PHASE),
    .BUSY      (BUSY),
    .CYC_DONE  (CYC_DONE),
    .CYCLE_CNT (CYCLE_CNT)
`ifdef PHASE_SEQ_ERR_EN
    ,
    .ERR       (ERR)
`endif
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("timeout: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push(input int at, input string tag, input logic [5:0] ph,
                      input logic busy, input logic done, input logic [7:0] cnt);
    exp_t e;
    e.at = at; e.tag = tag; e.ph = ph; e.busy = busy; e.done = done; e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic push_ph(inout int t, input logic [5:0] ph, input int n, inout bit d,
                         input logic [7:0] cnt, input string tag);
    for (int i = 0; i < n; i++) begin
      push(t, tag, ph, 1'b1, d, cnt);
      d = 1'b0;
      t++;
    end
  endtask

  // One expected pass P1..P5; only the first P1 cycle can carry CYC_DONE.
  task automatic push_run(inout int t, input bit skip, input bit done_first,
                          input logic [7:0] cnt, input string tag, input int p3_len);
    bit d;
    d = done_first;
    push_ph(t, S_P1, 4, d, cnt, tag);
    push_ph(t, S_P2, 2, d, cnt, tag);
    if (!skip) begin
      push_ph(t, S_P3, p3_len, d, cnt, tag);
      push_ph(t, S_P4, 3, d, cnt, tag);
    end
    push_ph(t, S_P5, 2, d, cnt, tag);
  endtask

  task automatic wait_until(input int at);
    while (cyc < at) @(negedge CLK);
  endtask

  // Monitor: every negedge, retire the scoreboard entries due this cycle.
  always @(negedge CLK) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      if (e.at != cyc || PHASE !== e.ph || BUSY !== e.busy ||
          CYC_DONE !== e.done || CYCLE_CNT !== e.cnt) begin
        n_bad++;
        $display("FAIL %s @cyc %0d (due %0d): actual ph=%b busy=%b done=%b cnt=%0d required ph=%b busy=%b done=%b cnt=%0d",
                 e.tag, cyc, e.at, PHASE, BUSY, CYC_DONE, CYCLE_CNT,
                 e.ph, e.busy, e.done, e.cnt);
      end
    end
  end

  initial begin
    int t;
    int c2, c3, c4, p3s, cl, i;
    logic [7:0] c;

    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    push(cyc + 1, "reset_state", S_IDLE, 1'b0, 1'b0, 8'd0);
    push(cyc + 2, "idle_run0", S_IDLE, 1'b0, 1'b0, 8'd0);
    wait_until(cyc + 2);

    // Full pass, then a SKIP pass, then a pass with HOLD inside P3.
    RUN = 1'b1;
    t = cyc + 1;
    push_run(t, 1'b0, 1'b0, 8'd0, "full", 3);
    c2 = t;
    push_run(t, 1'b1, 1'b1, 8'd1, "skip", 3);
    c3 = t;
    p3s = c3 + 6;
    push_run(t, 1'b0, 1'b1, 8'd2, "hold", 8);
    c4 = t;
    push_run(t, 1'b0, 1'b1, 8'd3, "pre_abort", 3);
    push(t, "abort_idle", S_IDLE, 1'b0, 1'b0, 8'd3);
    push(t + 1, "abort_stay", S_IDLE, 1'b0, 1'b0, 8'd3);

    wait_until(c2);
    SKIP = 1'b1;
    wait_until(c3);
    SKIP = 1'b0;
    wait_until(p3s + 1);
    HOLD = 1'b1;
    wait_until(p3s + 6);
    HOLD = 1'b0;
    wait_until(t - 1);
    ABORT = 1'b1;
    RUN   = 1'b0;
    wait_until(t);
    ABORT = 1'b0;
    wait_until(t + 1);

    // Continuous SKIP passes until the cycle counter wraps, then RUN drops in P2.
    RUN  = 1'b1;
    SKIP = 1'b1;
    t = cyc + 1;
    c = 8'd3;
    for (i = 0; i < 253; i++) begin
      push_run(t, 1'b1, (i != 0), c, "wrap", 3);
      c = c + 8'd1;
    end
    cl = t;
    push_run(t, 1'b1, 1'b1, 8'd0, "wrapped", 3);
    push(t, "drain_idle", S_IDLE, 1'b0, 1'b1, 8'd1);
    push(t + 1, "drain_idle2", S_IDLE, 1'b0, 1'b0, 8'd1);
    wait_until(cl + 4);
    RUN = 1'b0;
    wait_until(t + 1);

    // Asynchronous reset in the middle of P4.
    RUN  = 1'b1;
    SKIP = 1'b0;
    t = cyc + 1;
    cl = t;
    push_run(t, 1'b0, 1'b0, 8'd1, "pre_reset", 3);
    wait_until(cl + 10);
    check("pre_reset_p4", {10'd0, PHASE}, {10'd0, S_P4});
    #2 RESET = 1'b0;
    #1;
    check("async_phase", {10'd0, PHASE}, {10'd0, S_IDLE});
    check("async_busy", {15'd0, BUSY}, 16'd0);
    check("async_done", {15'd0, CYC_DONE}, 16'd0);
    check("async_cnt", {8'd0, CYCLE_CNT}, 16'd0);
    sb.delete();
    RUN = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    push(cyc + 1, "post_reset", S_IDLE, 1'b0, 1'b0, 8'd0);
    push(cyc + 2, "post_reset2", S_IDLE, 1'b0, 1'b0, 8'd0);
    wait_until(cyc + 2);

`ifdef PHASE_SEQ_ERR_EN
    check("err_clear", {15'd0, ERR}, 16'd0);
    force dut.phase_q = 6'b000110;
    @(posedge CLK);
    #1 release dut.phase_q;
    @(negedge CLK);
    check("err_set", {15'd0, ERR}, 16'd1);
    @(negedge CLK);
    check("err_idle", {10'd0, PHASE}, {10'd0, S_IDLE});
    repeat (3) @(negedge CLK);
    check("err_sticky", {15'd0, ERR}, 16'd1);
    RESET = 1'b0;
    #1;
    check("err_reset", {15'd0, ERR}, 16'd0);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
`endif

    @(negedge CLK);
    check("scoreboard_drained", sb.size(), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
